// File: rtl/sha_256_ctrl_pkg.sv
// Shared constants for the SHA-256 message sequencer: FSM encodings,
// digest mode selectors and the padding marker byte.
package sha_256_ctrl_pkg;

    typedef logic [2:0] sha_ctrl_state_t;

    localparam sha_ctrl_state_t ST_IDLE  = 3'd0;
    localparam sha_ctrl_state_t ST_FILL  = 3'd1;
    localparam sha_ctrl_state_t ST_PAD   = 3'd2;
    localparam sha_ctrl_state_t ST_LEN   = 3'd3;
    localparam sha_ctrl_state_t ST_ISSUE = 3'd4;
    localparam sha_ctrl_state_t ST_WAIT  = 3'd5;
    localparam sha_ctrl_state_t ST_DONE  = 3'd6;

    localparam logic SHA_MODE_224 = 1'b0;
    localparam logic SHA_MODE_256 = 1'b1;

    localparam logic [7:0]  SHA_PAD_BYTE = 8'h80;
    localparam logic [31:0] SHA_PAD_WORD = {SHA_PAD_BYTE, 24'h000000};

endpackage

// File: rtl/sha_256_ctrl_pad_word.sv
// Builds the final message word: keeps the first nbytes bytes (MSB-first),
// places the 0x80 marker right after them and zeroes everything below.
// nbytes of 4 or more passes the whole word through with no marker.
module sha_256_ctrl_pad_word
    import sha_256_ctrl_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] word_o
);

    // Per-byte select between data, marker and zero
    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes_i) begin
                word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
            end else if (3'(b) == nbytes_i) begin
                word_o[31-8*b -: 8] = SHA_PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha_256_ctrl.sv
// Message sequencer for the sha_256 compression core: collects 32-bit
// big-endian words into 512-bit blocks, appends padding and the bit length,
// hands each block to the core and returns the final digest as a pulse.
module sha_256_ctrl
    import sha_256_ctrl_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         in_ready,
    output logic [511:0] core_data,
    output logic [63:0]  core_index,
    output logic [1:0]   core_operation,
    output logic         core_enable,
    input  logic [255:0] core_hash,
    input  logic         core_ready,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    sha_ctrl_state_t     state_q, state_d;
    logic                mode_q, mode_d;
    logic [LEN_W-1:0]    bitlen_q, bitlen_d;
    logic [4:0]          wp_q, wp_d;
    logic [63:0]         index_q, index_d;
    logic                final_q, final_d;
    logic                pad_pending_q, pad_pending_d;
    logic                mark_q, mark_d;      // next PAD word carries the 0x80 marker
    logic                two_blk_q, two_blk_d; // marker landed in word 14..16
    logic [15:0][31:0]   blk_q, blk_d;
    logic [255:0]        digest_q, digest_d;

    logic [31:0]         last_word;
    logic [4:0]          marker_idx;
    logic [63:0]         len64;

    sha_256_ctrl_pad_word u_pad_word (
        .data_i   (in_data),
        .nbytes_i (in_nbytes),
        .word_o   (last_word)
    );

    assign marker_idx     = (in_nbytes >= 3'd4) ? wp_q + 5'd1 : wp_q;
    assign len64          = 64'(bitlen_q);

    assign in_ready       = (state_q == ST_FILL) && !wp_q[4];
    assign core_enable    = (state_q == ST_ISSUE);
    assign core_data      = blk_q;
    assign core_index     = index_q;
    assign core_operation = {1'b0, mode_q};
    assign digest         = digest_q;
    assign digest_valid   = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);

    // Next-state logic for the sequencer FSM and block buffer
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        bitlen_d      = bitlen_q;
        wp_d          = wp_q;
        index_d       = index_q;
        final_d       = final_q;
        pad_pending_d = pad_pending_q;
        mark_d        = mark_q;
        two_blk_d     = two_blk_q;
        blk_d         = blk_q;
        digest_d      = digest_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d        = mode;
                    bitlen_d      = '0;
                    wp_d          = '0;
                    index_d       = 64'd1;
                    final_d       = 1'b0;
                    pad_pending_d = 1'b0;
                    mark_d        = 1'b0;
                    two_blk_d     = 1'b0;
                    state_d       = ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid && in_ready) begin
                    wp_d = wp_q + 5'd1;
                    if (!in_last) begin
                        blk_d[wp_q[3:0]] = in_data;
                        bitlen_d         = bitlen_q + LEN_W'(32);
                        if (wp_q == 5'd15) begin
                            final_d = 1'b0;
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        blk_d[wp_q[3:0]] = last_word;
                        bitlen_d         = bitlen_q + LEN_W'({in_nbytes, 3'b000});
                        mark_d           = (in_nbytes >= 3'd4);
                        two_blk_d        = (marker_idx >= 5'd14);
                        state_d          = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                // Marker too close to the end: finish this block and carry
                // the length field into an extra block.
                if (two_blk_q ? wp_q[4] : (wp_q == 5'd14)) begin
                    if (two_blk_q) begin
                        pad_pending_d = 1'b1;
                        final_d       = 1'b0;
                        state_d       = ST_ISSUE;
                    end else begin
                        state_d = ST_LEN;
                    end
                end else begin
                    blk_d[wp_q[3:0]] = mark_q ? SHA_PAD_WORD : 32'h0;
                    mark_d           = 1'b0;
                    wp_d             = wp_q + 5'd1;
                end
            end
            ST_LEN: begin
                blk_d[14] = len64[63:32];
                blk_d[15] = len64[31:0];
                final_d   = 1'b1;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_ready) begin
                    index_d = index_q + 64'd1;
                    wp_d    = '0;
                    if (final_q) begin
                        digest_d = (mode_q == SHA_MODE_256) ? core_hash
                                                            : {core_hash[255:32], 32'h0};
                        state_d  = ST_DONE;
                    end else if (pad_pending_q) begin
                        // Extra block: all zero except a carried-over marker
                        pad_pending_d = 1'b0;
                        two_blk_d     = 1'b0;
                        blk_d         = '0;
                        if (mark_q) blk_d[0] = SHA_PAD_WORD;
                        mark_d        = 1'b0;
                        state_d       = ST_LEN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the shared async reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= SHA_MODE_224;
            bitlen_q      <= '0;
            wp_q          <= '0;
            index_q       <= '0;
            final_q       <= 1'b0;
            pad_pending_q <= 1'b0;
            mark_q        <= 1'b0;
            two_blk_q     <= 1'b0;
            blk_q         <= '0;
            digest_q      <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            bitlen_q      <= bitlen_d;
            wp_q          <= wp_d;
            index_q       <= index_d;
            final_q       <= final_d;
            pad_pending_q <= pad_pending_d;
            mark_q        <= mark_d;
            two_blk_q     <= two_blk_d;
            blk_q         <= blk_d;
            digest_q      <= digest_d;
        end
    end

endmodule

// File: tb/tb_sha_256_ctrl.sv
// Bench for sha_256_ctrl: behavioural SHA-256 core, software reference hash
// and a digest scoreboard, driven from one directed sequence.
module tb_sha_256_ctrl;

    localparam logic [255:0] H256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] H224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY256 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000;
    localparam logic [255:0] D56 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [255:0] dg;
        int           nblk;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = '0;
    logic         in_ready;
    logic [511:0] core_data;
    logic [63:0]  core_index;
    logic [1:0]   core_operation;
    logic         core_enable;
    logic [255:0] core_hash = '0;
    logic         core_ready = 1'b0;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    int           n_vec = 0;
    int           n_fail = 0;
    exp_t         sb[$];
    logic [7:0]   msg_q[$];
    logic [255:0] model_h = '0;
    int           busy_cnt = 0;
    int           en_total = 0;
    int           en_base = 0;
    int           ready_viol = 0;
    int           en_viol = 0;
    bit           post_last = 1'b0;
    logic         cur_mode = 1'b0;

    sha_256_ctrl #(.LEN_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_nbytes      (in_nbytes),
        .in_ready       (in_ready),
        .core_data      (core_data),
        .core_index     (core_index),
        .core_operation (core_operation),
        .core_enable    (core_enable),
        .core_hash      (core_hash),
        .core_ready     (core_ready),
        .digest         (digest),
        .digest_valid   (digest_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[t*32 +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Software hash of msg_q with its own padding
    function automatic logic [255:0] ref_hash(input logic m256);
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [255:0] h;
        logic [511:0] blk;
        p = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
        h = m256 ? H256 : H224;
        for (int bk = 0; bk < p.size() / 64; bk++) begin
            for (int i = 0; i < 16; i++)
                blk[i*32 +: 32] = {p[bk*64+4*i], p[bk*64+4*i+1], p[bk*64+4*i+2], p[bk*64+4*i+3]};
            h = compress(h, blk);
        end
        return m256 ? h : {h[255:32], 32'h0};
    endfunction

    task automatic core_step();
        if (!rst) begin
            busy_cnt = 0;
            core_ready = 1'b0;
        end else begin
            core_ready = 1'b0;
            if (busy_cnt > 0) begin
                if (core_enable) en_viol++;
                busy_cnt--;
                if (busy_cnt == 0) begin
                    core_ready = 1'b1;
                    core_hash = model_h;
                end
            end else if (core_enable) begin
                chk("core_index", 256'(core_index), 256'(en_total - en_base + 1));
                chk("core_operation", 256'(core_operation), 256'({1'b0, cur_mode}));
                en_total++;
                model_h = compress((core_index == 64'd1) ? (core_operation[0] ? H256 : H224) : model_h,
                                   core_data);
                busy_cnt = 128;
            end
        end
    endtask

    task automatic mon_step();
        exp_t e;
        if (!rst) begin
            en_base = en_total;
        end else if (digest_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_digest_valid", 256'(digest_valid), 256'(0));
            end else begin
                e = sb.pop_front();
                chk("digest", digest, e.dg);
                chk("block_count", 256'(en_total - en_base), 256'(e.nblk));
            end
            en_base = en_total;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        core_step();
        mon_step();
        if (post_last && in_ready) ready_viol++;
    endtask

    task automatic load_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(8'(s[i]));
    endtask

    task automatic load_rand(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_msg(input logic m, input bit gaps, input bit use_ref, input logic [255:0] known);
        exp_t e;
        int len, nw, nb, bi, g;
        bit acc;
        logic [31:0] wd;
        len = msg_q.size();
        e.dg = use_ref ? ref_hash(m) : known;
        e.nblk = (len + 8) / 64 + 1;
        sb.push_back(e);
        cur_mode = m;
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = ~m;
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) begin in_valid = 1'b0; tick(); end
            end
            nb = (w == nw - 1) ? len - 4 * w : 4;
            for (int k = 0; k < 4; k++) begin
                bi = 4 * w + k;
                wd[31-8*k -: 8] = (bi < len) ? msg_q[bi] : 8'hA5;
            end
            in_valid = 1'b1;
            in_data = wd;
            in_last = (w == nw - 1);
            in_nbytes = 3'(nb);
            acc = 1'b0;
            for (int t = 0; t < 2000 && !acc; t++) begin
                acc = in_ready;
                tick();
            end
            chk("word_accept", 256'(acc), 256'(1));
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        ready_viol = 0;
        post_last = 1'b1;
    endtask

    task automatic wait_idle(input bit junk);
        if (junk) begin
            in_valid = 1'b1;
            in_data = 32'hDEADBEEF;
        end
        for (int t = 0; t < 3000 && sb.size() > 0; t++) tick();
        chk("digest_timeout", 256'(sb.size()), 256'(0));
        in_valid = 1'b0;
        tick();
        post_last = 1'b0;
        chk("in_ready_outside_fill", 256'(ready_viol), 256'(0));
        chk("enable_while_busy", 256'(en_viol), 256'(0));
        chk("busy_after_done", 256'(busy), 256'(0));
        chk("digest_valid_one_cycle", 256'(digest_valid), 256'(0));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(0));
        chk({tag, "_core_enable"}, 256'(core_enable), 256'(0));
        chk({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_digest"}, digest, 256'(0));
        chk({tag, "_core_index"}, 256'(core_index), 256'(0));
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        check_reset("por");
        rst = 1'b1;
        tick();

        load_str("abc");
        run_msg(1'b1, 1'b0, 1'b0, ABC256);
        wait_idle(1'b0);

        msg_q.delete();
        run_msg(1'b1, 1'b0, 1'b0, EMPTY256);
        wait_idle(1'b0);

        load_str("abc");
        run_msg(1'b0, 1'b0, 1'b0, ABC224);
        wait_idle(1'b0);

        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        run_msg(1'b1, 1'b0, 1'b0, D56);
        wait_idle(1'b0);

        load_rand(55);
        run_msg(1'b1, 1'b1, 1'b1, '0);
        wait_idle(1'b1);

        load_rand(64);
        run_msg(1'b1, 1'b1, 1'b1, '0);
        wait_idle(1'b1);

        load_rand(60);
        run_msg(1'b0, 1'b1, 1'b1, '0);
        wait_idle(1'b0);

        load_rand(63);
        run_msg(1'b1, 1'b1, 1'b1, '0);
        wait_idle(1'b0);

        // Abandon a message while the core is working on it
        load_str("abc");
        run_msg(1'b1, 1'b0, 1'b0, ABC256);
        for (int t = 0; t < 200 && en_total == en_base; t++) tick();
        chk("enable_before_reset", 256'(en_total - en_base), 256'(1));
        repeat (20) tick();
        rst = 1'b0;
        sb.delete();
        post_last = 1'b0;
        tick();
        tick();
        check_reset("mid_wait");
        rst = 1'b1;
        repeat (200) tick();
        load_str("abc");
        run_msg(1'b1, 1'b0, 1'b0, ABC256);
        wait_idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
